// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Clear the byte-offset bits of a fetch target.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and decode.
// Synchronous FIFO with clear; push and pop may coincide, also when full.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];
  assign count     = cnt;

  // Pointer and occupancy bookkeeping; clear empties the buffer in one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents of empty slots are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues pipelined req/gnt/rvalid fetches,
// buffers returned words in a prefetch FIFO and presents the head to decode.
// Redirects clear the FIFO and drop responses still in flight.
// Optional: FETCH_MISALIGN_TRAP_EN makes a misaligned redirect target set a
// sticky misalign_o flag and halt fetching.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        incr_pc_i,
  input  logic        stall_i,
  input  logic        pc_load_i,
  input  logic [31:0] pc_load_addr_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] d_inst_o,
  output logic [31:0] d_pc_o,
  output logic        d_valid_o,
  output logic        misalign_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   pc_hold;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] out_next;
  logic [CW-1:0] discard_dec;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          load;
  logic          fire;
  logic          accept;
  logic          trap;
  logic          pop;
  logic          fifo_empty;
  logic [63:0]   head_data;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;

  // Request credit, handshake and response accounting for this cycle.
  always_comb begin
    load        = pc_load_i && (state != HALT);
    target      = word_align(pc_load_addr_i);
    credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req_o  = rst_n_i && (state != HALT) && !pc_load_i
                  && (credit_used < (CW + 1)'(FIFO_DEPTH))
                  && (outstanding < CW'(MAX_OUTST));
    fire        = imem_req_o && imem_gnt_i;
    accept      = imem_rvalid_i && !load && (discard == '0);
    out_next    = outstanding + CW'(fire) - CW'(imem_rvalid_i);
    discard_dec = (imem_rvalid_i && (discard != '0)) ? discard - CW'(1) : discard;
    pop         = !fifo_empty && incr_pc_i && !stall_i && !load;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap       = load && (pc_load_addr_i[1:0] != 2'b00);
  assign misalign_o = misalign_q;

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  misalign_q <= 1'b0;
    else if (trap) misalign_q <= 1'b1;
  end
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Fetch FSM with request/response PC counters and in-flight bookkeeping.
  // A redirect reloads discard with the post-cycle outstanding count, so a
  // response arriving in the redirect cycle is already excluded from it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (load) begin
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= out_next;
        if (trap)                state <= HALT;
        else if (out_next != '0) state <= FLUSH;
        else                     state <= RUN;
      end else begin
        if (fire)   fetch_pc <= fetch_pc + INST_BYTES;
        if (accept) resp_pc  <= resp_pc + INST_BYTES;
        discard <= discard_dec;
        case (state)
          RUN: begin
            if (halt_i) state <= HALT;
          end
          FLUSH: begin
            if (halt_i)                  state <= HALT;
            else if (discard_dec == '0)  state <= RUN;
          end
          HALT: begin
            state <= HALT;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

  // Remember the PC last shown to decode so it holds while the FIFO is empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)         pc_hold <= RESET_PC;
    else if (!fifo_empty) pc_hold <= head_pc;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear     (load),
    .push      (accept),
    .push_data ({resp_pc, imem_rdata_i}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_pc, head_inst} = head_data;
  assign imem_addr_o = fetch_pc;
  assign d_valid_o   = !fifo_empty;
  assign d_inst_o    = fifo_empty ? NOP_INST : head_inst;
  assign d_pc_o      = fifo_empty ? pc_hold : head_pc;

endmodule
